// File: rtl/stuffed_nrzi_tx_if.sv
// Frame request/handshake bundle for stuffed_nrzi_tx.
//   SIE           : serial interface enable (gates frame acceptance only)
//   STUFF_OPER_tx : bit-stuffing enable, sampled at accept
//   sync_data     : sync/flag pattern, sampled at accept
//   data_in       : payload, sampled at accept
//   data_valid    : upstream has a frame to send
//   data_ready    : transmitter can accept a frame this cycle
// master = upstream frame source, slave = transmitter.
interface stuffed_nrzi_tx_if #(
  parameter int DATA_W = 16,
  parameter int SYNC_W = 8
);
  logic              SIE;
  logic              STUFF_OPER_tx;
  logic [SYNC_W-1:0] sync_data;
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;

  modport master (output SIE, STUFF_OPER_tx, sync_data, data_in, data_valid,
                  input  data_ready);
  modport slave  (input  SIE, STUFF_OPER_tx, sync_data, data_in, data_valid,
                  output data_ready);
endinterface

// File: rtl/stuffed_nrzi_tx.sv
// Serial frame transmitter: SYNC pattern, bit-stuffed payload, NRZI line
// coding, forced-low EOP and a single high IDLE_J cycle.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   tx (slave)      : frame request handshake and frame contents
//   encoded_dataout : registered NRZI line
//   SYNC_pattern    : line currently carries a sync bit
//   opcode          : phase of the bit on the line (IDLE..IDLE_J = 0..5)
//   busy            : opcode != IDLE
module stuffed_nrzi_tx #(
  parameter int DATA_W    = 16,
  parameter int SYNC_W    = 8,
  parameter int STUFF_LEN = 6,
  parameter int EOP_LEN   = 2
) (
  input  logic                clk,
  input  logic                rst,
  stuffed_nrzi_tx_if.slave    tx,
  output logic                encoded_dataout,
  output logic                SYNC_pattern,
  output logic [3:0]          opcode,
  output logic                busy
);
  localparam int MAXW  = (DATA_W > SYNC_W) ? DATA_W : SYNC_W;
  localparam int PTR_W = $clog2(MAXW);
  localparam int RUN_W = $clog2(STUFF_LEN + 1);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_SYNC   = 4'd1,
    ST_DATA   = 4'd2,
    ST_STUFF  = 4'd3,
    ST_EOP    = 4'd4,
    ST_IDLE_J = 4'd5
  } state_t;

  state_t            state_q, state_d;
  logic              line_q, line_d;
  logic              lvl_q, lvl_d;       // NRZI reference (last coded level)
  logic [SYNC_W-1:0] sync_q, sync_d;     // MSB is the sync bit on the line
  logic [DATA_W-1:0] data_q, data_d;     // MSB is the payload bit on the line
  logic              stuff_en_q, stuff_en_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;       // bits remaining in current phase
  logic [RUN_W-1:0]  run_q, run_d;

  logic accept;
  logic nrzi;        // next line bit is NRZI coded
  logic bit_d;       // logical value of the next coded bit
  logic lvl_src;     // reference the next coded bit is measured against
  logic payload;     // next bit is a payload bit (drives the run counter)
  logic run_first;   // first payload bit: run starts from zero

  assign tx.data_ready = (state_q == ST_IDLE) && tx.SIE && !rst;
  assign accept        = tx.data_valid && tx.data_ready;

  always_comb begin
    state_d    = state_q;
    sync_d     = sync_q;
    data_d     = data_q;
    stuff_en_d = stuff_en_q;
    ptr_d      = ptr_q;
    run_d      = run_q;
    nrzi       = 1'b0;
    bit_d      = 1'b1;
    lvl_src    = lvl_q;
    payload    = 1'b0;
    run_first  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_SYNC;
          sync_d     = tx.sync_data;
          data_d     = tx.data_in;
          stuff_en_d = tx.STUFF_OPER_tx;
          ptr_d      = PTR_W'(SYNC_W - 1);
          nrzi       = 1'b1;
          bit_d      = tx.sync_data[SYNC_W-1];
          lvl_src    = 1'b1;               // every frame starts from a high reference
        end
      end
      ST_SYNC: begin
        nrzi = 1'b1;
        if (ptr_q == '0) begin
          state_d   = ST_DATA;
          ptr_d     = PTR_W'(DATA_W - 1);
          bit_d     = data_q[DATA_W-1];
          payload   = 1'b1;
          run_first = 1'b1;
        end else begin
          sync_d = sync_q << 1;
          ptr_d  = ptr_q - 1'b1;
          bit_d  = sync_q[SYNC_W-2];
        end
      end
      ST_DATA, ST_STUFF: begin
        // Stuff check comes before the end-of-payload check so a run that
        // ends on the last payload bit still gets its stuffed zero.
        if (state_q == ST_DATA && stuff_en_q && run_q == RUN_W'(STUFF_LEN)) begin
          state_d = ST_STUFF;
          nrzi    = 1'b1;
          bit_d   = 1'b0;
          run_d   = '0;
        end else if (ptr_q == '0) begin
          state_d = ST_EOP;
          ptr_d   = PTR_W'(EOP_LEN - 1);
        end else begin
          state_d = ST_DATA;
          data_d  = data_q << 1;
          ptr_d   = ptr_q - 1'b1;
          nrzi    = 1'b1;
          bit_d   = data_q[DATA_W-2];
          payload = 1'b1;
        end
      end
      ST_EOP: begin
        if (ptr_q == '0) state_d = ST_IDLE_J;
        else             ptr_d   = ptr_q - 1'b1;
      end
      ST_IDLE_J: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (payload) begin
      if (!bit_d)                           run_d = '0;
      else if (run_first)                   run_d = RUN_W'(1);
      else if (run_q != {RUN_W{1'b1}})      run_d = run_q + 1'b1;  // saturate when stuffing is off
    end

    if (nrzi) begin
      line_d = bit_d ? lvl_src : ~lvl_src;   // 0 toggles, 1 holds
      lvl_d  = line_d;
    end else begin
      line_d = (state_d != ST_EOP);          // EOP forced low, IDLE_J/IDLE high
      lvl_d  = (state_d == ST_EOP) ? lvl_q : 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      line_q     <= 1'b1;
      lvl_q      <= 1'b1;
      sync_q     <= '0;
      data_q     <= '0;
      stuff_en_q <= 1'b0;
      ptr_q      <= '0;
      run_q      <= '0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      lvl_q      <= lvl_d;
      sync_q     <= sync_d;
      data_q     <= data_d;
      stuff_en_q <= stuff_en_d;
      ptr_q      <= ptr_d;
      run_q      <= run_d;
    end
  end

  assign encoded_dataout = line_q;
  assign opcode          = state_q;
  assign busy            = (state_q != ST_IDLE);
  assign SYNC_pattern    = (state_q == ST_SYNC);
endmodule
